ftoi_issue_arbiter: RTL and testbench
=====================================

// Module: ftoi_issue_arbiter
// PURPOSE
//  Shares one fixed-latency ftoi conversion pipeline between NREQ requesters (issue slots / aux units).
//  Arbitrates round-robin, issues at most one op per cycle, tracks tag/source through the pipeline
//  shadow, and buffers results in a FIFO so a stalled consumer never loses a result.
//  Sits between the FPU issue logic and the ftoi datapath. The ftoi datapath itself has no stall input.
// PARAMETERS
//  NREQ       2   number of requesters (>=2)
//  LAT        2   ftoi latency in cycles, op sampled at edge k -> result valid after edge k+LAT
//  TAG_W      5   destination-register tag width
//  FIFO_DEPTH 4   result buffer entries (>= LAT+1 for full throughput)
// PORTS
//  clk         in   1            system clock, rising edge
//  reset       in   1            asynchronous, active-low reset
//  req_valid   in   NREQ         per-requester op valid
//  req_ready   out  NREQ         grant; handshake when valid&ready
//  req_op      in   NREQ*32      packed float32 operands, slot i at [32*i+:32]
//  req_tag     in   NREQ*TAG_W   packed destination tags
//  ftoi_op     out  32           operand to ftoi datapath (registered)
//  ftoi_result in   32           ftoi datapath output
//  resp_valid  out  1            FIFO head valid
//  resp_ready  in   1            consumer accepts head
//  resp_data   out  32           converted int32
//  resp_tag    out  TAG_W        tag of head
//  resp_src    out  clog2(NREQ)  requester index of head
// BEHAVIOUR
//  Reset (async, reset==0): req_ready=0, ftoi_op=0, resp_valid=0, resp_data/tag/src=0; rr pointer=0,
//   shadow valids=0, FIFO empty, credit count=0. Pending in-flight ops are dropped. Stale ftoi output is
//   ignored because the shadow valids are cleared.
//  Credits: cnt = in-flight ops + FIFO occupancy. Issue is allowed only when cnt < FIFO_DEPTH.
//   Update: cnt += issue - pop. A simultaneous issue and pop leaves cnt unchanged.
//  Arbitration (combinational, same cycle): if issue allowed, grant the first i with req_valid[i],
//   searching from rr pointer upward with wrap. req_ready is one-hot or zero. req_ready never depends
//   on resp_ready except through cnt.
//  On grant: ftoi_op <= req_op[i]; shadow stage0 <= {1, tag, i}; rr <= (i+1) mod NREQ.
//   Without a grant, ftoi_op holds its value, stage0 valid <= 0, and rr holds.
//  Shadow: LAT-stage shift register of {valid, tag, src}, aligned so stage LAT-1 coincides with the
//   matching ftoi_result.
//  FIFO write: when stage LAT-1 valid, push {ftoi_result, tag, src}. Overflow cannot occur (credits).
//  FIFO read: resp_* = head. A pop happens on resp_valid & resp_ready.
//   Push and pop in the same cycle on a full FIFO is legal.
//   Push to an empty FIFO makes resp_valid=1 on the next cycle (no bypass).
//  Latency: grant at edge k -> resp_valid at edge k+LAT+1 when the FIFO is empty and ready.
//   Sustained throughput is 1 op/cycle when resp_ready=1.
//  Ordering: responses leave in issue order. Per-requester order is preserved.
//  Requester must hold req_op/req_tag stable while valid & !ready. Dropping valid without a handshake
//   is allowed.
//  Pointer wrap: rr wraps NREQ-1 -> 0. Credit counter width is clog2(FIFO_DEPTH+1), no wrap.
// STRUCTURE
//  Shared package fpu_pkg: FTOI_LAT=2, TAG_W default, and typedef ftoi_meta_t {tag, src}.
//  The ftoi datapath is reused unchanged and instantiated by the parent, not inside this block.
//  One sub-module: fpu_result_fifo (sync FIFO, async active-low reset; params WIDTH, DEPTH; ports
//   push/pop/full/empty/count).
//  Arbiter, credit counter and shadow shift register stay in this module.
// TESTING
//  1 Single op: req0 op=0x40490FDB (3.14159), tag=3, resp_ready=1 -> after LAT+1 cycles:
//    resp_data=0x00000003, tag=3, src=0.
//  2 Round-robin: both valid every cycle, ops 0x40200000 (2.5) and 0xBFC00000 (-1.5) ->
//    grants alternate 0,1,0,1; responses alternate 0x00000003 / 0xFFFFFFFE.
//  3 Backpressure: resp_ready=0, req0 streaming -> exactly FIFO_DEPTH=4 grants, then req_ready=0.
//    Raise resp_ready -> 4 results drain in order, issue resumes with cnt never > 4.
//  4 Simultaneous push/pop at full: FIFO full, resp_ready=1 and req valid -> 1 pop + 1 issue per cycle,
//    count stays 4, no loss.
//  5 Async reset mid-stream: assert reset with 2 ops in flight and 2 buffered -> outputs 0 immediately.
//    After release, no stale response appears and the next op is returned correctly.
//  6 Sparse valid: req1 only, valid every 3rd cycle, rr at 0 -> req1 granted same cycle each time.
//    Responses are LAT+1 cycles later.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: ftoi pipeline latency, default tag width and result metadata.
package fpu_pkg;

    localparam int unsigned FTOI_LAT   = 2;
    localparam int unsigned FTOI_TAG_W = 5;
    localparam int unsigned FTOI_SRC_W = 1;

    // Metadata that travels alongside an ftoi op (default two-requester configuration)
    typedef struct packed {
        logic [FTOI_TAG_W-1:0] tag;
        logic [FTOI_SRC_W-1:0] src;
    } ftoi_meta_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO; head is presented combinationally, zero when empty.
module fpu_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; a push into a full FIFO with a pop overwrites the slot being read out
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ftoi_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared fixed-latency ftoi pipeline, with
// credit-based flow control and a result FIFO that absorbs consumer stalls.
module ftoi_issue_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned LAT        = FTOI_LAT,
    parameter int unsigned TAG_W      = FTOI_TAG_W,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SRC_W     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*32-1:0]    req_op,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic [31:0]           ftoi_op,
    input  logic [31:0]           ftoi_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [TAG_W-1:0]      resp_tag,
    output logic [SRC_W-1:0]      resp_src
);

    localparam int unsigned ENTRY_W = 32 + TAG_W + SRC_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0] rr_q, rr_d;
    logic [31:0]      ftoi_op_q, ftoi_op_d;
    logic [LAT-1:0]   sh_vld_q, sh_vld_d;
    logic [TAG_W-1:0] sh_tag_q [LAT];
    logic [TAG_W-1:0] sh_tag_d [LAT];
    logic [SRC_W-1:0] sh_src_q [LAT];
    logic [SRC_W-1:0] sh_src_d [LAT];

    logic             issue_ok, grant_any, push, pop, fifo_full, fifo_empty;
    logic [SRC_W-1:0] grant_idx;
    logic [CNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Round-robin search from rr_q; credits cover both in-flight ops and buffered results
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        issue_ok  = reset && (cnt_q < CNT_W'(FIFO_DEPTH));
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (issue_ok && !grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state for operand register, rr pointer, shadow pipeline and credit counter
    always_comb begin
        ftoi_op_d   = ftoi_op_q;
        rr_d        = rr_q;
        sh_vld_d    = {sh_vld_q[LAT-2:0], grant_any};
        sh_tag_d[0] = req_tag[TAG_W*grant_idx +: TAG_W];
        sh_src_d[0] = grant_idx;
        for (int unsigned j = 1; j < LAT; j++) begin
            sh_tag_d[j] = sh_tag_q[j-1];
            sh_src_d[j] = sh_src_q[j-1];
        end
        if (grant_any) begin
            ftoi_op_d = req_op[32*grant_idx +: 32];
            rr_d      = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        unique case ({grant_any, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset clears shadow valids so stale datapath output is never captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            rr_q      <= '0;
            ftoi_op_q <= '0;
            sh_vld_q  <= '0;
            for (int unsigned j = 0; j < LAT; j++) begin
                sh_tag_q[j] <= '0;
                sh_src_q[j] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            ftoi_op_q <= ftoi_op_d;
            sh_vld_q  <= sh_vld_d;
            for (int unsigned j = 0; j < LAT; j++) begin
                sh_tag_q[j] <= sh_tag_d[j];
                sh_src_q[j] <= sh_src_d[j];
            end
        end
    end

    assign push = sh_vld_q[LAT-1];
    assign pop  = resp_valid && resp_ready;

    fpu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .wdata ({ftoi_result, sh_tag_q[LAT-1], sh_src_q[LAT-1]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ftoi_op                          = ftoi_op_q;
    assign resp_valid                       = !fifo_empty;
    assign {resp_data, resp_tag, resp_src}  = fifo_rdata;

    // Credits must always cover the buffer, so a push never lands on a full FIFO without a pop
    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!reset)
        (cnt_q >= fifo_count) && !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ftoi_issue_arbiter.sv
// Scoreboard bench for ftoi_issue_arbiter with a behavioural ftoi datapath model.
module tb_ftoi_issue_arbiter;
    import fpu_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned LAT   = 2;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SRC_W = 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*32-1:0]    req_op = '0;
    logic [NREQ*TAG_W-1:0] req_tag = '0;
    logic [31:0]           ftoi_op;
    logic [31:0]           ftoi_result;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [31:0]           resp_data;
    logic [TAG_W-1:0]      resp_tag;
    logic [SRC_W-1:0]      resp_src;

    ftoi_issue_arbiter #(
        .NREQ       (NREQ),
        .LAT        (LAT),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_tag     (req_tag),
        .ftoi_op     (ftoi_op),
        .ftoi_result (ftoi_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_tag    (resp_tag),
        .resp_src    (resp_src)
    );

    typedef struct {
        logic [31:0] data;
        ftoi_meta_t  meta;
        int unsigned cyc;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad = 0;
    int unsigned     cyc = 0;
    int unsigned     tb_rr = 0;
    int unsigned     n_pop = 0;
    bit              chk_lat = 1'b0;
    logic [NREQ-1:0] hs_seen = '0;

    // float32 -> int32, round half away from zero, saturating
    function automatic logic [31:0] ftoi_ref(input logic [31:0] x);
        int          e;
        int          sh;
        logic [63:0] m;
        logic [63:0] mag;
        logic [31:0] r;
        e = int'(x[30:23]);
        m = {40'd0, 1'b1, x[22:0]};
        if (e < 126) return 32'd0;
        if (e >= 158) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        sh = 150 - e;
        if (sh <= 0) mag = m << (-sh);
        else         mag = (m + (64'd1 << (sh - 1))) >> sh;
        r = mag[31:0];
        return x[31] ? (~r + 32'd1) : r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        e = 8'($urandom_range(157, 100));
        return {1'($urandom_range(1)), e, 23'($urandom)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ftoi datapath stand-in: result lags ftoi_op by LAT-1 register stages
    logic [31:0] dp_q [LAT-1];
    always_ff @(posedge clk) begin
        dp_q[0] <= ftoi_ref(ftoi_op);
        for (int k = 1; k < LAT - 1; k++) dp_q[k] <= dp_q[k-1];
    end
    assign ftoi_result = dp_q[LAT-2];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Issue observer: checks grants against the round-robin/credit rule, pushes expectations
    initial forever begin
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] hs;
        bit              found;
        int unsigned     idx;
        exp_t            e;
        @(negedge clk);
        if (!reset) begin
            sb.delete();
            tb_rr   = 0;
            hs_seen = '0;
        end else begin
            exp_rdy = '0;
            found   = 0;
            if (sb.size() < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (tb_rr + k) % NREQ;
                    if (!found && req_valid[idx]) begin
                        exp_rdy[idx] = 1'b1;
                        found = 1;
                    end
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            hs = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    e.data     = ftoi_ref(req_op[32*i +: 32]);
                    e.meta.tag = req_tag[TAG_W*i +: TAG_W];
                    e.meta.src = SRC_W'(i);
                    e.cyc      = cyc;
                    sb.push_back(e);
                    tb_rr = (i + 1) % NREQ;
                end
            end
            hs_seen = hs;
        end
    end

    // Response monitor: pops the scoreboard on every consumer handshake
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (reset && resp_valid && resp_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'(resp_data), 64'hDEAD_0000_0000);
            end else begin
                e = sb.pop_front();
                check("resp_data", 64'(resp_data), 64'(e.data));
                check("resp_tag", 64'(resp_tag), 64'(e.meta.tag));
                check("resp_src", 64'(resp_src), 64'(e.meta.src));
                if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(LAT + 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] op, input logic [TAG_W-1:0] tag);
        req_op[32*i +: 32]     = op;
        req_tag[TAG_W*i +: TAG_W] = tag;
    endtask

    task automatic issue_one(input int i, input logic [31:0] op, input logic [TAG_W-1:0] tag);
        bit done;
        done = 0;
        set_slot(i, op, tag);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (hs_seen[i]) done = 1;
        end
        req_valid[i] = 1'b0;
        if (!done) check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic stream0(input int ncyc, input int max_grants, output int ng);
        ng = 0;
        set_slot(0, rand_op(), TAG_W'($urandom));
        req_valid[0] = 1'b1;
        repeat (ncyc) begin
            tick();
            if (hs_seen[0]) begin
                ng++;
                set_slot(0, rand_op(), TAG_W'($urandom));
            end
            if (ng >= max_grants) req_valid[0] = 1'b0;
        end
        req_valid[0] = 1'b0;
    endtask

    task automatic drain(input string name);
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
        repeat (2) tick();
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int          ng;
        int unsigned pops0;

        // Reset state
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_ftoi_op", 64'(ftoi_op), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_head", 64'({resp_data, resp_tag, resp_src}), 64'd0);
        #21 reset = 1'b1;
        resp_ready = 1'b1;
        tick();

        // 1: single op, pi -> 3
        chk_lat = 1;
        issue_one(0, 32'h40490FDB, 5'd3);
        for (int n = 0; n < 10 && !resp_valid; n++) tick();
        check("t1_data", 64'(resp_data), 64'h3);
        check("t1_tag", 64'(resp_tag), 64'd3);
        check("t1_src", 64'(resp_src), 64'd0);
        drain("t1_drain");

        // 2: both requesters valid every cycle
        set_slot(0, 32'h40200000, 5'd1);
        set_slot(1, 32'hBFC00000, 5'd2);
        req_valid = '1;
        repeat (10) tick();
        drain("t2_drain");

        // 3/4: backpressure fills exactly DEPTH credits, then simultaneous issue and pop
        chk_lat    = 0;
        resp_ready = 1'b0;
        stream0(10, 100, ng);
        check("t3_grants", 64'(ng), 64'(DEPTH));
        req_valid[0] = 1'b1;
        #1;
        check("t3_blocked", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        stream0(12, 100, ng);
        drain("t4_drain");

        // 5: async reset with two ops in flight and two buffered
        resp_ready = 1'b0;
        stream0(4, 4, ng);
        check("t5_grants", 64'(ng), 64'd4);
        check("t5_pre_valid", 64'(resp_valid), 64'd1);
        #3 reset = 1'b0;
        #1;
        check("t5_rst_valid", 64'(resp_valid), 64'd0);
        check("t5_rst_head", 64'({resp_data, resp_tag, resp_src}), 64'd0);
        check("t5_rst_op", 64'(ftoi_op), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        tick();
        resp_ready = 1'b1;
        chk_lat    = 1;
        pops0      = n_pop;
        issue_one(1, 32'hC2F6E979, 5'd17);
        repeat (8) tick();
        check("t5_one_resp", 64'(n_pop - pops0), 64'd1);

        // 6: sparse requester 1 is granted in the cycle it raises valid
        for (int r = 0; r < 4; r++) begin
            set_slot(1, rand_op(), TAG_W'($urandom));
            req_valid[1] = 1'b1;
            #1;
            check("t6_same_cycle", 64'(req_ready[1]), 64'd1);
            tick();
            req_valid[1] = 1'b0;
            repeat (2) tick();
        end
        drain("t6_drain");

        // Random traffic with random consumer stalls
        chk_lat = 0;
        repeat (300) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !hs_seen[i])) begin
                    req_valid[i] = ($urandom_range(99) < 60);
                    set_slot(i, rand_op(), TAG_W'($urandom));
                end else if ($urandom_range(99) < 5) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(99) < 70);
            tick();
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
